// File: rtl/pc_sequencer.sv
// ==== pc_sequencer : fetch-side PC owner, single outstanding fetch, redirect/trap/drain ====
// ==== rev 1.0                                                                           ====
`default_nettype none

module pc_sequencer #(
  parameter int unsigned                 ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0]     RESET_VECTOR = '0,
  parameter logic [ADDRESS_SIZE-1:0]     TRAP_VECTOR  = 'h100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    fetch_req_o,
  output logic [ADDRESS_SIZE-1:0] fetch_addr_o,
  input  logic                    fetch_ready_i,
  input  logic                    fetch_rsp_valid_i,
  input  logic [31:0]             fetch_rsp_data_i,
  output logic                    instr_valid_o,
  output logic [31:0]             instr_o,
  output logic [ADDRESS_SIZE-1:0] instr_pc_o,
  input  logic                    instr_ready_i,
  input  logic                    redirect_valid_i,
  input  logic [ADDRESS_SIZE-1:0] redirect_target_i,
  input  logic                    trap_i,
  input  logic [ADDRESS_SIZE-1:0] trap_pc_i,
  input  logic                    mret_i,
  output logic [ADDRESS_SIZE-1:0] epc_o,
  output logic                    misaligned_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDRESS_SIZE-1:0] PC_STEP = {{(ADDRESS_SIZE-3){1'b0}}, 3'd4};

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic [ADDRESS_SIZE-1:0] epc_q, epc_d;
  logic [ADDRESS_SIZE-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]             instr_q, instr_d;
  logic                    instr_valid_q, instr_valid_d;
  logic                    misaligned_q, misaligned_d;

  logic                    buf_free;
  logic                    fetch_accept;
  logic                    redirect;
  logic                    tgt_misaligned;
  logic                    capture;
  logic [ADDRESS_SIZE-1:0] redirect_pc;

  assign buf_free       = !instr_valid_q || instr_ready_i;
  assign fetch_req_o    = (state_q == S_REQ) && buf_free;
  assign fetch_accept   = fetch_req_o && fetch_ready_i;
  assign redirect       = trap_i || mret_i || redirect_valid_i;
  assign tgt_misaligned = redirect_target_i[1:0] != 2'b00;
  // A response arriving together with a redirect belongs to the old path.
  assign capture        = (state_q == S_WAIT) && fetch_rsp_valid_i && !redirect;

  always_comb begin
    redirect_pc = redirect_target_i;
    if (trap_i)              redirect_pc = TRAP_VECTOR;
    else if (mret_i)         redirect_pc = epc_q;
    else if (tgt_misaligned) redirect_pc = TRAP_VECTOR;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = redirect_valid_i && !trap_i && !mret_i && tgt_misaligned;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (fetch_accept) state_d = redirect ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (fetch_rsp_valid_i) state_d = S_REQ;
        else if (redirect)     state_d = S_DRAIN;
      end
      S_DRAIN: if (fetch_rsp_valid_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
      if (trap_i)                        epc_d = trap_pc_i;
      else if (!mret_i && tgt_misaligned) epc_d = redirect_target_i;
    end else if (capture) begin
      instr_d       = fetch_rsp_data_i;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + PC_STEP;
    end else if (instr_ready_i) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign fetch_addr_o  = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign epc_o         = epc_q;
  assign misaligned_o  = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ==== tb_pc_sequencer : directed + random stimulus against a transaction-level fetch model ====
// ==== rev 1.0                                                                               ====
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ready_i = 1'b0;
  logic        fetch_rsp_valid_i = 1'b0;
  logic [31:0] fetch_rsp_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        mret_i = 1'b0;
  logic [31:0] epc_o;
  logic        misaligned_o;

  pc_sequencer #(
    .ADDRESS_SIZE (32),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_req_o       (fetch_req_o),
    .fetch_addr_o      (fetch_addr_o),
    .fetch_ready_i     (fetch_ready_i),
    .fetch_rsp_valid_i (fetch_rsp_valid_i),
    .fetch_rsp_data_i  (fetch_rsp_data_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_ready_i     (instr_ready_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_i            (trap_i),
    .trap_pc_i         (trap_pc_i),
    .mret_i            (mret_i),
    .epc_o             (epc_o),
    .misaligned_o      (misaligned_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: architectural PC/EPC, decode buffer, and the fate of the
  // single in-flight fetch (0 none, 1 live, 2 stale).
  logic [31:0] m_pc, m_epc, m_bi, m_bpc, m_oaddr;
  bit          m_bv, m_mis, m_boot, m_req;
  int          m_out;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_bi = 32'h0; m_bpc = 32'h0; m_oaddr = 32'h0;
    m_bv = 1'b0; m_mis = 1'b0; m_boot = 1'b1; m_out = 0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req"},   {31'b0, fetch_req_o},   32'h0);
    chk({p, "_addr"},  fetch_addr_o,           32'h0);
    chk({p, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
    chk({p, "_instr"}, instr_o,                32'h0);
    chk({p, "_ipc"},   instr_pc_o,             32'h0);
    chk({p, "_epc"},   epc_o,                  32'h0);
    chk({p, "_mis"},   {31'b0, misaligned_o},  32'h0);
  endtask

  // One cycle: called at a negedge, drives inputs, checks outputs against the
  // model, advances the model, returns at the next negedge.
  task automatic step(input bit rdy, input bit ir, input bit tr, input logic [31:0] tpc,
                      input bit mr, input bit rv, input logic [31:0] tgt, input bit rsp_en);
    bit          rsp, acc, redir, cap;
    logic [31:0] npc;
    rsp = rsp_en && (m_out != 0);
    fetch_ready_i     = rdy;
    instr_ready_i     = ir;
    trap_i            = tr;
    trap_pc_i         = tpc;
    mret_i            = mr;
    redirect_valid_i  = rv;
    redirect_target_i = tgt;
    fetch_rsp_valid_i = rsp;
    fetch_rsp_data_i  = rsp ? memw(m_oaddr) : $urandom;
    #1;
    m_req = !m_boot && (m_out == 0) && (!m_bv || ir);
    chk("fetch_req",   {31'b0, fetch_req_o},   {31'b0, m_req});
    chk("fetch_addr",  fetch_addr_o,           m_pc);
    chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, m_bv});
    chk("instr",       instr_o,                m_bi);
    chk("instr_pc",    instr_pc_o,             m_bpc);
    chk("epc",         epc_o,                  m_epc);
    chk("misaligned",  {31'b0, misaligned_o},  {31'b0, m_mis});

    acc   = m_req && rdy;
    redir = tr || mr || rv;
    cap   = rsp && (m_out == 1) && !redir;
    if (tr)                 npc = TV;
    else if (mr)            npc = m_epc;
    else if (tgt[1:0] != 0) npc = TV;
    else                    npc = tgt;

    if (rsp)                       m_out = 0;
    else if (acc)                  begin m_out = redir ? 2 : 1; m_oaddr = m_pc; end
    else if (m_out == 1 && redir)  m_out = 2;

    if (redir)       m_bv = 1'b0;
    else if (cap)    begin m_bv = 1'b1; m_bi = memw(m_oaddr); m_bpc = m_oaddr; end
    else if (ir)     m_bv = 1'b0;

    if (tr)                              m_epc = tpc;
    else if (!mr && rv && tgt[1:0] != 0) m_epc = tgt;

    if (redir)     m_pc = npc;
    else if (cap)  m_pc = m_pc + 32'd4;

    m_mis  = rv && !tr && !mr && (tgt[1:0] != 0);
    m_boot = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_step(input bit rdy, input bit ir, input bit rsp_en);
    step(rdy, ir, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rsp_en);
  endtask

  task automatic rand_steps(input int n);
    logic [31:0] r, tgt;
    int          sel;
    for (int i = 0; i < n; i++) begin
      r   = $urandom;
      sel = $urandom_range(0, 3);
      tgt = (sel == 0) ? r : {r[31:2], 2'b00};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 39) == 0,
           $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // Reset release and first fetch
    idle_step(1, 0, 0);
    chk("first_addr", fetch_addr_o, 32'h0);
    idle_step(1, 0, 0);
    idle_step(1, 0, 1);
    chk("first_instr",  instr_o,                32'h0000_0013);
    chk("first_ipc",    instr_pc_o,             32'h0);
    chk("first_valid",  {31'b0, instr_valid_o}, 32'h1);
    chk("second_addr",  fetch_addr_o,           32'h4);

    // Backpressure
    repeat (3) idle_step(1, 0, 0);
    chk("bp_pc_hold", fetch_addr_o, 32'h4);
    idle_step(1, 1, 0);

    // Redirect while waiting; stale word returned later
    step(0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 0);
    idle_step(0, 0, 0);
    idle_step(0, 0, 1);
    chk("drain_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("drain_addr",  fetch_addr_o,           32'h40);
    idle_step(1, 0, 0);
    idle_step(0, 0, 1);
    chk("redir_ipc", instr_pc_o, 32'h40);

    // Trap and return
    step(0, 0, 1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 0);
    chk("trap_addr", fetch_addr_o, TV);
    chk("trap_epc",  epc_o,        32'h1C);
    step(0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    chk("mret_addr", fetch_addr_o, 32'h1C);

    // Priority, then misaligned target
    step(0, 0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h80, 0);
    chk("prio_addr", fetch_addr_o, TV);
    chk("prio_epc",  epc_o,        32'h200);
    step(0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h42, 0);
    chk("mis_pulse", {31'b0, misaligned_o}, 32'h1);
    chk("mis_addr",  fetch_addr_o,          TV);
    chk("mis_epc",   epc_o,                 32'h42);
    idle_step(0, 0, 0);
    chk("mis_end",   {31'b0, misaligned_o}, 32'h0);

    // PC wrap
    step(0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
    idle_step(1, 1, 0);
    idle_step(0, 1, 1);
    chk("wrap_ipc",  instr_pc_o,   32'hFFFF_FFFC);
    chk("wrap_addr", fetch_addr_o, 32'h0);

    rand_steps(1500);

    // Asynchronous reset in the middle of a fetch
    idle_step(1, 1, 1);
    idle_step(1, 1, 0);
    #3;
    rst_n = 1'b0;
    fetch_rsp_valid_i = 1'b0;
    #1;
    chk_reset("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rand_steps(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
